// File: rtl/trace_tap.sv
// Purpose: tags instructions entering I with sequence IDs and follows them through X/M/R for the trace printer.
// Latency: every output is registered, so each reports the event of the previous clk edge (1 cycle).
// Backpressure: adv=0 holds all slots and ignores i_v; flush kills the I entry and the incoming instruction.
//
// Ports: clk, reset (async, active-low); i_v/i_pc/i_inst present an instruction; adv advances the pipe;
// flush kills I; pcv/pc_x redirect from X; rdv/rd_m/rd_data writeback from M.
// Outputs: inst_v_{i,x,m,r} with ci/cx/cm/cr stage-entry pulses; valid/pc/inst retire record;
// rdv_o/rd_o/rd_data_o writeback record; pcv_o/pc_x_o redirect record; flush_v/cf killed-ID report.
// Optional feature: define TRACE_FLUSH_REPORT_EN to build the killed-ID report; otherwise flush_v/cf are 0.
module trace_tap #(
    parameter int ID_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_v,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_inst,
    input  logic        adv,
    input  logic        flush,
    input  logic        pcv,
    input  logic [31:0] pc_x,
    input  logic        rdv,
    input  logic [4:0]  rd_m,
    input  logic [31:0] rd_data,
    output logic        inst_v_i,
    output logic        inst_v_x,
    output logic        inst_v_m,
    output logic        inst_v_r,
    output logic [31:0] ci,
    output logic [31:0] cx,
    output logic [31:0] cm,
    output logic [31:0] cr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        rdv_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rd_data_o,
    output logic        pcv_o,
    output logic [31:0] pc_x_o,
    output logic        flush_v,
    output logic [31:0] cf
);

    function automatic logic [31:0] ext_id(input logic [ID_W-1:0] id);
        ext_id           = '0;
        ext_id[ID_W-1:0] = id;
    endfunction

    // ID counter; wraps naturally at 2^ID_W.
    logic [ID_W-1:0] cnt;

    // I, X and M slots. The R slot is the retire output register set itself:
    // it is consumed on the same edge it would be overwritten, so it needs no
    // separate storage.
    logic            si_v, sx_v, sm_v;
    logic [ID_W-1:0] si_id, sx_id, sm_id;
    logic [31:0]     si_pc, sx_pc, sm_pc;
    logic [31:0]     si_inst, sx_inst, sm_inst;

    logic accept;
    logic mv_x;
    logic mv_m;
    logic mv_r;

    always_comb begin
        accept = i_v & adv & ~flush;
        // A flushed I entry never reaches X, even when the pipe advances.
        mv_x   = adv & si_v & ~flush;
        mv_m   = adv & sx_v;
        mv_r   = adv & sm_v;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            si_v    <= 1'b0;
            si_id   <= '0;
            si_pc   <= '0;
            si_inst <= '0;
            sx_v    <= 1'b0;
            sx_id   <= '0;
            sx_pc   <= '0;
            sx_inst <= '0;
            sm_v    <= 1'b0;
            sm_id   <= '0;
            sm_pc   <= '0;
            sm_inst <= '0;
        end else begin
            if (accept) begin
                cnt     <= cnt + ID_W'(1);
                si_v    <= 1'b1;
                si_id   <= cnt;
                si_pc   <= i_pc;
                si_inst <= i_inst;
            end else if (adv || flush) begin
                si_v    <= 1'b0;
            end
            if (adv) begin
                sx_v    <= mv_x;
                sx_id   <= si_id;
                sx_pc   <= si_pc;
                sx_inst <= si_inst;
                sm_v    <= sx_v;
                sm_id   <= sx_id;
                sm_pc   <= sx_pc;
                sm_inst <= sx_inst;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_v_i  <= 1'b0;
            inst_v_x  <= 1'b0;
            inst_v_m  <= 1'b0;
            inst_v_r  <= 1'b0;
            ci        <= '0;
            cx        <= '0;
            cm        <= '0;
            cr        <= '0;
            valid     <= 1'b0;
            pc        <= '0;
            inst      <= '0;
            rdv_o     <= 1'b0;
            rd_o      <= '0;
            rd_data_o <= '0;
            pcv_o     <= 1'b0;
            pc_x_o    <= '0;
        end else begin
            // Pulses mark a new arrival only, so a held stage never re-pulses.
            inst_v_i  <= accept;
            inst_v_x  <= mv_x;
            inst_v_m  <= mv_m;
            inst_v_r  <= mv_r;
            valid     <= mv_r;
            ci        <= ext_id(cnt);
            cx        <= ext_id(si_id);
            cm        <= ext_id(sx_id);
            cr        <= ext_id(sm_id);
            if (mv_r) begin
                pc   <= sm_pc;
                inst <= sm_inst;
            end
            // Side-band records are only meaningful when their stage holds a live entry.
            rdv_o     <= rdv & sm_v;
            rd_o      <= rd_m;
            rd_data_o <= rd_data;
            pcv_o     <= pcv & sx_v;
            pc_x_o    <= pc_x;
        end
    end

`ifdef TRACE_FLUSH_REPORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_v <= 1'b0;
            cf      <= '0;
        end else begin
            flush_v <= flush & si_v;
            cf      <= ext_id(si_id);
        end
    end
`else
    assign flush_v = 1'b0;
    assign cf      = '0;
`endif

endmodule
